// File: rtl/rv_scheduler_ctrl.sv
// rtl/rv_scheduler_ctrl.sv - RV32I scheduler control: forwarding selects, load-use stall, branch flush, event counters.
// Shadows rd/reg-write/load metadata through EX/MEM/WB so hazard decode needs only ID-stage inputs.
module rv_scheduler_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D,
  input  logic                      rs1_usedD,
  input  logic                      rs2_usedD,
  input  logic [REG_ADDR_WIDTH-1:0] rdD,
  input  logic                      reg_wrD,
  input  logic                      mem_rdD,
  input  logic                      branch_takenE,
  input  logic                      hold,
  output logic [1:0]                forward_rs1E,
  output logic [1:0]                forward_rs2E,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushD,
  output logic                      flushE,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;

  logic [REG_ADDR_WIDTH-1:0] e_rd_q, e_rd_d;
  logic                      e_wr_q, e_wr_d;
  logic                      e_ld_q, e_ld_d;
  logic [REG_ADDR_WIDTH-1:0] e_rs1_q, e_rs1_d;
  logic [REG_ADDR_WIDTH-1:0] e_rs2_q, e_rs2_d;
  logic [REG_ADDR_WIDTH-1:0] m_rd_q, m_rd_d;
  logic                      m_wr_q, m_wr_d;
  logic [REG_ADDR_WIDTH-1:0] w_rd_q, w_rd_d;
  logic                      w_wr_q, w_wr_d;
  logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]      flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_f, stall_d, flush_d, flush_e;

  // MEM beats WB; x0 is hardwired so a write to it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                         input logic [REG_ADDR_WIDTH-1:0] m_rd,
                                         input logic                      m_wr,
                                         input logic [REG_ADDR_WIDTH-1:0] w_rd,
                                         input logic                      w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wr && (m_rd != REG_ZERO) && (m_rd == rs)) begin
      sel = 2'b11;
    end else if (w_wr && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    forward_rs1E = fwd_sel(e_rs1_q, m_rd_q, m_wr_q, w_rd_q, w_wr_q);
    forward_rs2E = fwd_sel(e_rs2_q, m_rd_q, m_wr_q, w_rd_q, w_wr_q);
  end

  always_comb begin
    load_use = e_ld_q && e_wr_q && (e_rd_q != REG_ZERO) &&
               ((rs1_usedD && (rs1D == e_rd_q)) || (rs2_usedD && (rs2D == e_rd_q)));
  end

  // A taken branch squashes the ID instruction anyway, so it overrides a load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (branch_takenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign stallF    = stall_f;
  assign stallD    = stall_d;
  assign flushD    = flush_d;
  assign flushE    = flush_e;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    e_rd_d      = e_rd_q;
    e_wr_d      = e_wr_q;
    e_ld_d      = e_ld_q;
    e_rs1_d     = e_rs1_q;
    e_rs2_d     = e_rs2_q;
    m_rd_d      = m_rd_q;
    m_wr_d      = m_wr_q;
    w_rd_d      = w_rd_q;
    w_wr_d      = w_wr_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      w_rd_d = m_rd_q;
      w_wr_d = m_wr_q;
      m_rd_d = e_rd_q;
      m_wr_d = e_wr_q;
      if (flush_e) begin
        e_rd_d  = '0;
        e_wr_d  = 1'b0;
        e_ld_d  = 1'b0;
        e_rs1_d = '0;
        e_rs2_d = '0;
      end else begin
        e_rd_d  = rdD;
        e_wr_d  = reg_wrD;
        e_ld_d  = mem_rdD;
        e_rs1_d = rs1D;
        e_rs2_d = rs2D;
      end
      if (flush_d && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      if (stall_d && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rd_q      <= '0;
      e_wr_q      <= 1'b0;
      e_ld_q      <= 1'b0;
      e_rs1_q     <= '0;
      e_rs2_q     <= '0;
      m_rd_q      <= '0;
      m_wr_q      <= 1'b0;
      w_rd_q      <= '0;
      w_wr_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_rd_q      <= e_rd_d;
      e_wr_q      <= e_wr_d;
      e_ld_q      <= e_ld_d;
      e_rs1_q     <= e_rs1_d;
      e_rs2_q     <= e_rs2_d;
      m_rd_q      <= m_rd_d;
      m_wr_q      <= m_wr_d;
      w_rd_q      <= w_rd_d;
      w_wr_q      <= w_wr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_scheduler_ctrl.sv
// tb/tb_rv_scheduler_ctrl.sv - self-checking bench for rv_scheduler_ctrl against an instruction-level pipeline model.
module tb_rv_scheduler_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        rs1_usedD, rs2_usedD, reg_wrD, mem_rdD, branch_takenE, hold;
  logic [1:0]  forward_rs1E, forward_rs2E;
  logic        stallF, stallD, flushD, flushE;
  logic [15:0] stall_cnt, flush_cnt;

  rv_scheduler_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD), .rs2_usedD(rs2_usedD),
    .rdD(rdD), .reg_wrD(reg_wrD), .mem_rdD(mem_rdD),
    .branch_takenE(branch_takenE), .hold(hold),
    .forward_rs1E(forward_rs1E), .forward_rs2E(forward_rs2E),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t      pipe [3];
  int unsigned m_stall, m_flush;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Youngest older instruction writing the register supplies it.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].wr && pipe[s].rd != 0 && pipe[s].rd == rs) return (s == 1) ? 2'b11 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_lu();
    return pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 &&
           ((rs1_usedD && rs1D == pipe[0].rd) || (rs2_usedD && rs2D == pipe[0].rd));
  endfunction

  function automatic void model_update();
    logic br, lu;
    if (hold) return;
    br = branch_takenE;
    lu = exp_lu();
    if (br) begin
      if (m_flush < 65535) m_flush++;
    end else if (lu) begin
      if (m_stall < 65535) m_stall++;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (br || lu) ? instr_t'('0) : '{rd: rdD, wr: reg_wrD, ld: mem_rdD, rs1: rs1D, rs2: rs2D};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic efd, efe, esf;
    if (hold) begin
      esf = 1'b1; efd = 1'b0; efe = 1'b0;
    end else if (branch_takenE) begin
      esf = 1'b0; efd = 1'b1; efe = 1'b1;
    end else if (exp_lu()) begin
      esf = 1'b1; efd = 1'b0; efe = 1'b1;
    end else begin
      esf = 1'b0; efd = 1'b0; efe = 1'b0;
    end
    chk("fwd_rs1", 32'(forward_rs1E), 32'(exp_fwd(pipe[0].rs1)));
    chk("fwd_rs2", 32'(forward_rs2E), 32'(exp_fwd(pipe[0].rs2)));
    chk("stallF", 32'(stallF), 32'(esf));
    chk("stallD", 32'(stallD), 32'(esf));
    chk("flushD", 32'(flushD), 32'(efd));
    chk("flushE", 32'(flushE), 32'(efe));
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("flush_cnt", 32'(flush_cnt), m_flush);
  endtask

  task automatic ins(input logic [4:0] rd, input logic wr, input logic ld,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic br = 1'b0, input logic hd = 1'b0);
    rdD = rd; reg_wrD = wr; mem_rdD = ld;
    rs1D = rs1; rs1_usedD = u1; rs2D = rs2; rs2_usedD = u2;
    branch_takenE = br; hold = hd;
  endtask

  task automatic nop();
    ins(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic look();
    #3;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [1:0] held_f1, held_f2;

  initial begin
    rst_n = 1'b0;
    nop();
    model_reset();
    #2;
    check_all();
    chk("reset_stallF", 32'(stallF), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU chain: add x5; sub x6,x5,x1; or x9,x5,x0
    ins(5'd5, 1, 0, 5'd1, 1, 5'd2, 1); look(); tick();
    ins(5'd6, 1, 0, 5'd5, 1, 5'd1, 1); look(); tick();
    ins(5'd9, 1, 0, 5'd5, 1, 5'd0, 0); look();
    chk("alu_rs1_mem", 32'(forward_rs1E), 32'd3);
    chk("alu_rs2_none", 32'(forward_rs2E), 32'd0);
    tick();
    nop(); look();
    chk("alu_rs1_wb", 32'(forward_rs1E), 32'd2);
    tick();

    // Double write to x7, then both to x0
    ins(5'd7, 1, 0, 5'd1, 1, 5'd2, 1); look(); tick();
    ins(5'd7, 1, 0, 5'd0, 1, 5'd0, 0); look(); tick();
    ins(5'd11, 1, 0, 5'd7, 1, 5'd7, 1); look(); tick();
    nop(); look();
    chk("dbl_mem_wins", 32'(forward_rs1E), 32'd3);
    tick();
    ins(5'd0, 1, 0, 5'd1, 1, 5'd2, 1); look(); tick();
    ins(5'd0, 1, 0, 5'd0, 1, 5'd0, 0); look(); tick();
    ins(5'd12, 1, 0, 5'd0, 1, 5'd0, 1); look(); tick();
    nop(); look();
    chk("x0_no_fwd", 32'(forward_rs1E), 32'd0);
    tick();

    // Load-use: lw x8; add x10,x3,x8
    ins(5'd8, 1, 1, 5'd1, 1, 5'd0, 0); look(); tick();
    ins(5'd10, 1, 0, 5'd3, 1, 5'd8, 1); look();
    chk("lu_stallF", 32'(stallF), 32'd1);
    chk("lu_flushE", 32'(flushE), 32'd1);
    tick();
    look();
    chk("lu_one_cycle", 32'(stallF), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    nop(); look();
    chk("lu_consumer_fwd", 32'(forward_rs2E), 32'd2);
    tick();

    // Branch taken while load-use pending
    ins(5'd8, 1, 1, 5'd1, 1, 5'd0, 0); look(); tick();
    ins(5'd10, 1, 0, 5'd3, 1, 5'd8, 1, 1'b1); look();
    chk("br_flushD", 32'(flushD), 32'd1);
    chk("br_stallF", 32'(stallF), 32'd0);
    tick();
    nop(); look();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Hold for 3 cycles with a load-use pending
    ins(5'd8, 1, 1, 5'd1, 1, 5'd0, 0); look(); tick();
    ins(5'd10, 1, 0, 5'd3, 1, 5'd8, 1, 1'b0, 1'b1); look();
    held_f1 = forward_rs1E;
    held_f2 = forward_rs2E;
    for (int i = 0; i < 3; i++) begin
      tick(); look();
      chk("hold_fwd1", 32'(forward_rs1E), 32'(held_f1));
      chk("hold_fwd2", 32'(forward_rs2E), 32'(held_f2));
      chk("hold_stall_cnt", 32'(stall_cnt), 32'd1);
    end
    tick();
    ins(5'd10, 1, 0, 5'd3, 1, 5'd8, 1); look();
    chk("hold_rel_flushE", 32'(flushE), 32'd1);
    tick(); look();
    chk("hold_rel_once", 32'(flushE), 32'd0);
    chk("hold_rel_cnt", 32'(stall_cnt), 32'd2);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ins(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      look();
      tick();
    end

    // Asynchronous reset in the middle of a stall
    ins(5'd8, 1, 1, 5'd1, 1, 5'd0, 0); look(); tick();
    ins(5'd10, 1, 0, 5'd3, 1, 5'd8, 1); look();
    chk("pre_rst_stall", 32'(stallF), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_stallF", 32'(stallF), 32'd0);
    chk("rst_flushE", 32'(flushE), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Flush counter saturation
    ins(5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1'b1);
    for (int n = 0; n < 65534; n++) tick();
    look();
    chk("sat_fffe", 32'(flush_cnt), 32'h0000_FFFE);
    for (int n = 0; n < 3; n++) begin
      tick(); look();
    end
    chk("sat_ffff", 32'(flush_cnt), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
